// File: rtl/execute_muldiv.sv
// Execute stage: single-cycle ALU / branch / forwarding plus an iterative RV M-extension unit.
// Optional build macro MULDIV_FAST_MUL_EN selects a single-cycle combinational multiplier.
module execute_muldiv #(
    parameter int XLEN  = 64,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] RD1_E,
    input  logic [XLEN-1:0] RD2_E,
    input  logic [XLEN-1:0] ImmExt_E,
    input  logic [XLEN-1:0] PC_E,
    input  logic [XLEN-1:0] ALUResult_M,
    input  logic [XLEN-1:0] Result_W,
    input  logic [4:0]      ALUControl_E,
    input  logic            ALUSrc_E,
    input  logic            Branch_E,
    input  logic            Jump_E,
    input  logic            is_jalr_E,
    input  logic [2:0]      funct3_E,
    input  logic [1:0]      ForwardA_E,
    input  logic [1:0]      ForwardB_E,
    input  logic            MulDiv_E,
    input  logic            Flush_E,
    output logic [XLEN-1:0] ALUResult_E,
    output logic [XLEN-1:0] WriteData_E,
    output logic [XLEN-1:0] PCTarget_E,
    output logic            PCSrc_E,
    output logic            Zero_E,
    output logic            Busy_E
);

    localparam int SH_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_AND  = 5'd2;
    localparam logic [4:0] ALU_OR   = 5'd3;
    localparam logic [4:0] ALU_XOR  = 5'd4;
    localparam logic [4:0] ALU_SLT  = 5'd5;
    localparam logic [4:0] ALU_SLTU = 5'd6;
    localparam logic [4:0] ALU_SLL  = 5'd7;
    localparam logic [4:0] ALU_SRL  = 5'd8;
    localparam logic [4:0] ALU_SRA  = 5'd9;
    localparam logic [4:0] ALU_PASB = 5'd10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [XLEN-1:0] src_a, src_b, rs2_fwd;
    logic [XLEN-1:0] alu_result;
    logic            alu_zero;
    logic            taken;
    logic [XLEN-1:0] jalr_target;

    // Iterative datapath: hi/lo hold the product halves (MUL) or remainder/quotient (DIV).
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  hi_q, lo_q, opb_q, res_q;
    logic [1:0]       op_q;
    logic             neg_q, rneg_q;

    logic            accept, last;
    logic            a_signed, b_signed, sign_a, sign_b;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            div_zero, div_ovf;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_step, mul_fix;
    logic [XLEN-1:0]   mul_res;

    logic [XLEN:0]   div_shift;
    logic            div_ge;
    logic [XLEN-1:0] div_rem, div_quo, div_res;

    // ---------------- forwarding and integer path ----------------
    always_comb begin
        case (ForwardA_E)
            2'b10:   src_a = ALUResult_M;
            2'b01:   src_a = Result_W;
            default: src_a = RD1_E;
        endcase
        case (ForwardB_E)
            2'b10:   rs2_fwd = ALUResult_M;
            2'b01:   rs2_fwd = Result_W;
            default: rs2_fwd = RD2_E;
        endcase
    end

    assign src_b       = ALUSrc_E ? ImmExt_E : rs2_fwd;
    assign WriteData_E = rs2_fwd;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        alu_result = src_a + src_b;
        case (ALUControl_E)
            ALU_ADD:  alu_result = src_a + src_b;
            ALU_SUB:  alu_result = src_a - src_b;
            ALU_AND:  alu_result = src_a & src_b;
            ALU_OR:   alu_result = src_a | src_b;
            ALU_XOR:  alu_result = src_a ^ src_b;
            ALU_SLT:  alu_result = XLEN'($signed(src_a) < $signed(src_b));
            ALU_SLTU: alu_result = XLEN'(src_a < src_b);
            ALU_SLL:  alu_result = src_a << src_b[SH_W-1:0];
            ALU_SRL:  alu_result = src_a >> src_b[SH_W-1:0];
            ALU_SRA:  alu_result = $signed(src_a) >>> src_b[SH_W-1:0];
            ALU_PASB: alu_result = src_b;
            default:  alu_result = src_a + src_b;
        endcase
    end

    assign alu_zero = (alu_result == '0);
    assign Zero_E   = alu_zero;

    always_comb begin
        case (funct3_E)
            3'b000:  taken = alu_zero;
            3'b001:  taken = ~alu_zero;
            3'b100,
            3'b110:  taken = alu_result[0];
            3'b101,
            3'b111:  taken = ~alu_result[0];
            default: taken = 1'b0;
        endcase
    end

    assign jalr_target = (src_a + ImmExt_E) & ~XLEN'(1);
    assign PCTarget_E  = is_jalr_E ? jalr_target : (PC_E + ImmExt_E);
    assign PCSrc_E     = ~MulDiv_E & (Jump_E | (Branch_E & taken));

    assign ALUResult_E = (state_q == S_DONE) ? res_q : alu_result;

    // ---------------- M-op operand preparation (accept cycle) ----------------
    assign accept = (state_q == S_IDLE) & MulDiv_E & ~Flush_E;

    // MUL/MULH treat both operands as signed, MULHSU only rs1, MULHU neither.
    assign a_signed = funct3_E[2] ? ~funct3_E[0] : (funct3_E[1:0] != 2'b11);
    assign b_signed = funct3_E[2] ? ~funct3_E[0] : ~funct3_E[1];
    assign sign_a   = a_signed & src_a[XLEN-1];
    assign sign_b   = b_signed & rs2_fwd[XLEN-1];
    assign mag_a    = sign_a ? -src_a : src_a;
    assign mag_b    = sign_b ? -rs2_fwd : rs2_fwd;

    assign div_zero = funct3_E[2] & (rs2_fwd == '0);
    assign div_ovf  = funct3_E[2] & ~funct3_E[0] & (src_a == MOST_NEG) & (rs2_fwd == '1);

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_mag, fast_fix;
    logic [XLEN-1:0]   fast_res;

    assign fast_mag = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
    assign fast_fix = (sign_a ^ sign_b) ? -fast_mag : fast_mag;
    assign fast_res = (funct3_E[1:0] == 2'b00) ? fast_fix[XLEN-1:0] : fast_fix[2*XLEN-1:XLEN];
`endif

    // ---------------- iteration step logic ----------------
    assign last = (cnt_q == CNT_W'(XLEN - 1));

    assign mul_sum  = {1'b0, hi_q} + {1'b0, opb_q & {XLEN{lo_q[0]}}};
    assign mul_step = {mul_sum, lo_q[XLEN-1:1]};
    assign mul_fix  = neg_q ? -mul_step : mul_step;
    assign mul_res  = (op_q == 2'b00) ? mul_fix[XLEN-1:0] : mul_fix[2*XLEN-1:XLEN];

    assign div_shift = {hi_q, lo_q[XLEN-1]};
    assign div_ge    = (div_shift >= {1'b0, opb_q});
    assign div_rem   = div_ge ? XLEN'(div_shift - {1'b0, opb_q}) : div_shift[XLEN-1:0];
    assign div_quo   = {lo_q[XLEN-2:0], div_ge};
    assign div_res   = op_q[1] ? (rneg_q ? -div_rem : div_rem)
                               : (neg_q  ? -div_quo : div_quo);

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        Busy_E  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    Busy_E = 1'b1;
                    if (div_zero || div_ovf) state_d = S_DONE;
`ifdef MULDIV_FAST_MUL_EN
                    else if (!funct3_E[2])   state_d = S_DONE;
`endif
                    else if (funct3_E[2])    state_d = S_DIV;
                    else                     state_d = S_MUL;
                end
            end
            S_MUL: begin
                Busy_E = 1'b1;
                if (last) state_d = S_DONE;
            end
            S_DIV: begin
                Busy_E = 1'b1;
                if (last) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (Flush_E) begin
            state_d = S_IDLE;
            Busy_E  = 1'b0;
        end
        if (rst) Busy_E = 1'b0;
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        // NOTE: the datapath is a handful of flops, not a memory, so it is cleared on reset like control state.
        if (rst) begin
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            opb_q  <= '0;
            res_q  <= '0;
            op_q   <= '0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_q   <= funct3_E[1:0];
                        neg_q  <= sign_a ^ sign_b;
                        rneg_q <= sign_a;
                        cnt_q  <= '0;
                        hi_q   <= '0;
                        lo_q   <= funct3_E[2] ? mag_a : mag_b;
                        opb_q  <= funct3_E[2] ? mag_b : mag_a;
                        if (div_zero)     res_q <= funct3_E[1] ? src_a : '1;
                        else if (div_ovf) res_q <= funct3_E[1] ? '0 : src_a;
`ifdef MULDIV_FAST_MUL_EN
                        else if (!funct3_E[2]) res_q <= fast_res;
`endif
                    end
                end
                S_MUL: begin
                    hi_q  <= mul_step[2*XLEN-1:XLEN];
                    lo_q  <= mul_step[XLEN-1:0];
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last) res_q <= mul_res;
                end
                S_DIV: begin
                    hi_q  <= div_rem;
                    lo_q  <= div_quo;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last) res_q <= div_res;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_execute_muldiv.sv
// Directed testbench for execute_muldiv: table-driven ALU/branch vectors, M-op vectors,
// and hand-written flush / reset / back-to-back sequences.
module tb_execute_muldiv;

    localparam int XLEN = 64;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = XLEN + 1;
`endif
    localparam int DIV_LAT = XLEN + 1;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_XOR  = 5'd4;
    localparam logic [4:0] ALU_SLT  = 5'd5;
    localparam logic [4:0] ALU_SLTU = 5'd6;
    localparam logic [4:0] ALU_SLL  = 5'd7;
    localparam logic [4:0] ALU_SRA  = 5'd9;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;

    logic            clk, rst;
    logic [XLEN-1:0] rd1, rd2, imm, pc, alu_m, res_w;
    logic [4:0]      alu_ctl;
    logic            alu_src, branch, jump, jalr;
    logic [2:0]      funct3;
    logic [1:0]      fwd_a, fwd_b;
    logic            muldiv, flush;
    logic [XLEN-1:0] alu_result, write_data, pc_target;
    logic            pc_src, zero, busy;

    int n_cmp = 0;
    int n_err = 0;

    execute_muldiv #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .RD1_E(rd1), .RD2_E(rd2), .ImmExt_E(imm), .PC_E(pc),
        .ALUResult_M(alu_m), .Result_W(res_w),
        .ALUControl_E(alu_ctl), .ALUSrc_E(alu_src), .Branch_E(branch),
        .Jump_E(jump), .is_jalr_E(jalr), .funct3_E(funct3),
        .ForwardA_E(fwd_a), .ForwardB_E(fwd_b),
        .MulDiv_E(muldiv), .Flush_E(flush),
        .ALUResult_E(alu_result), .WriteData_E(write_data),
        .PCTarget_E(pc_target), .PCSrc_E(pc_src), .Zero_E(zero), .Busy_E(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  fa, fb;
        logic [63:0] r1, r2, am, rw, im, p;
        logic [4:0]  ctl;
        logic        src, br, jmp, jr;
        logic [2:0]  f3;
        logic [63:0] e_res;
        logic        e_zero, e_pcsrc;
        logic [63:0] e_tgt, e_wd;
    } alu_vec_t;

    typedef struct {
        logic [63:0] a, b;
        logic [2:0]  f3;
        logic [63:0] e_res;
        int          lat;
        string       name;
    } m_vec_t;

    alu_vec_t av[12];
    m_vec_t   mv[17];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_mop(input logic [63:0] a, input logic [63:0] b, input logic [2:0] f3,
                           input logic [63:0] exp_res, input int exp_lat, input string name);
        int n;
        fwd_a = 2'b00; fwd_b = 2'b00; alu_src = 1'b0; branch = 1'b0; jump = 1'b0; jalr = 1'b0;
        alu_ctl = ALU_ADD; rd1 = a; rd2 = b; funct3 = f3; muldiv = 1'b1;
        #1;
        n = 0;
        while (busy && n < 200) begin
            n++;
            step();
        end
        check({name, "_lat"}, 64'(n), 64'(exp_lat));
        check({name, "_res"}, alu_result, exp_res);
        muldiv = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1; muldiv = 1'b1; flush = 1'b0;
        rd1 = '0; rd2 = '0; imm = '0; pc = '0; alu_m = '0; res_w = '0;
        alu_ctl = ALU_ADD; alu_src = 1'b0; branch = 1'b0; jump = 1'b0; jalr = 1'b0;
        funct3 = 3'b000; fwd_a = 2'b00; fwd_b = 2'b00;

        //      fa     fb     rd1           rd2    alu_m  res_w  imm          pc       ctl       src br j jr f3      res             z  ps tgt      wd
        av[0]  = '{2'b10, 2'b00, 64'd99,        64'd7,   64'd5, 64'd0,    64'd0,    64'd0,      ALU_ADD,  0, 0, 0, 0, 3'b000, 64'd12,         0, 0, 64'd0,      64'd7};
        av[1]  = '{2'b00, 2'b00, ONES,          64'd1,   64'd0, 64'd0,    64'h20,   64'h100,    ALU_SLT,  0, 1, 0, 0, 3'b100, 64'd1,          0, 1, 64'h120,    64'd1};
        av[2]  = '{2'b00, 2'b00, 64'h205,       64'h33,  64'd0, 64'd0,    64'd0,    64'h80,     ALU_ADD,  1, 0, 1, 1, 3'b000, 64'h205,        0, 1, 64'h204,    64'h33};
        av[3]  = '{2'b01, 2'b00, 64'd0,         64'd9,   64'd0, 64'd9,    ONES - 7, 64'h40,     ALU_SUB,  0, 1, 0, 0, 3'b000, 64'd0,          1, 1, 64'h38,     64'd9};
        av[4]  = '{2'b01, 2'b00, 64'd0,         64'd9,   64'd0, 64'd9,    ONES - 7, 64'h40,     ALU_SUB,  0, 1, 0, 0, 3'b001, 64'd0,          1, 0, 64'h38,     64'd9};
        av[5]  = '{2'b00, 2'b00, 64'd1,         ONES,    64'd0, 64'd0,    64'h10,   64'h200,    ALU_SLTU, 0, 1, 0, 0, 3'b111, 64'd1,          0, 0, 64'h210,    ONES};
        av[6]  = '{2'b00, 2'b10, 64'd20,        64'd100, 64'd3, 64'd0,    64'd0,    64'd0,      ALU_SUB,  0, 0, 0, 0, 3'b000, 64'd17,         0, 0, 64'd0,      64'd3};
        av[7]  = '{2'b00, 2'b00, ONES - 15,     64'd0,   64'd0, 64'd0,    64'd2,    64'd0,      ALU_SRA,  1, 0, 0, 0, 3'b000, ONES - 3,       0, 0, 64'd2,      64'd0};
        av[8]  = '{2'b00, 2'b00, 64'd5,         64'd3,   64'd0, 64'd0,    64'h100,  64'h1000,   ALU_SLT,  0, 1, 0, 0, 3'b101, 64'd0,          1, 1, 64'h1100,   64'd3};
        av[9]  = '{2'b00, 2'b00, 64'd4,         64'd4,   64'd0, 64'd0,    64'd4,    64'd0,      ALU_SUB,  0, 1, 0, 0, 3'b010, 64'd0,          1, 0, 64'd4,      64'd4};
        av[10] = '{2'b00, 2'b01, 64'hFF,        64'd1,   64'd0, 64'hF0,   64'd0,    64'd0,      ALU_XOR,  0, 0, 0, 0, 3'b000, 64'h0F,         0, 0, 64'd0,      64'hF0};
        av[11] = '{2'b00, 2'b00, 64'd1,         64'd0,   64'd0, 64'd0,    64'd63,   64'd0,      ALU_SLL,  1, 0, 0, 0, 3'b000, MIN,            0, 0, 64'd63,     64'd0};

        mv[0]  = '{64'd3,  ONES - 3, 3'b000, ONES - 11, MUL_LAT, "mul_3x-4"};
        mv[1]  = '{ONES,   ONES,     3'b011, ONES - 1,  MUL_LAT, "mulhu_ones"};
        mv[2]  = '{ONES,   ONES,     3'b001, 64'd0,     MUL_LAT, "mulh_-1x-1"};
        mv[3]  = '{ONES,   ONES,     3'b010, ONES,      MUL_LAT, "mulhsu_-1xones"};
        mv[4]  = '{MIN,    64'd2,    3'b001, ONES,      MUL_LAT, "mulh_minx2"};
        mv[5]  = '{ONES - 6, 64'd2,  3'b100, ONES - 2,  DIV_LAT, "div_-7/2"};
        mv[6]  = '{ONES - 6, 64'd2,  3'b110, ONES,      DIV_LAT, "rem_-7/2"};
        mv[7]  = '{64'd7,  ONES - 1, 3'b100, ONES - 2,  DIV_LAT, "div_7/-2"};
        mv[8]  = '{64'd7,  ONES - 1, 3'b110, 64'd1,     DIV_LAT, "rem_7/-2"};
        mv[9]  = '{64'd10, 64'd3,    3'b101, 64'd3,     DIV_LAT, "divu_10/3"};
        mv[10] = '{64'd10, 64'd3,    3'b111, 64'd1,     DIV_LAT, "remu_10/3"};
        mv[11] = '{64'd5,  64'd0,    3'b101, ONES,      1,       "divu_5/0"};
        mv[12] = '{64'd5,  64'd0,    3'b110, 64'd5,     1,       "rem_5/0"};
        mv[13] = '{MIN,    ONES,     3'b100, MIN,       1,       "div_ovf"};
        mv[14] = '{MIN,    ONES,     3'b110, 64'd0,     1,       "rem_ovf"};
        mv[15] = '{MIN,    ONES,     3'b101, 64'd0,     DIV_LAT, "divu_min/ones"};
        mv[16] = '{ONES - 6, 64'd0,  3'b100, ONES,      1,       "div_-7/0"};

        // reset: Busy_E stays low even with an M-op pending
        step();
        step();
        check("busy_in_reset", 64'(busy), 64'd0);
        rst = 1'b0;
        muldiv = 1'b0;
        step();
        check("busy_after_reset", 64'(busy), 64'd0);
        check("result_after_reset", alu_result, 64'd0);

        for (int i = 0; i < 12; i++) begin
            fwd_a = av[i].fa; fwd_b = av[i].fb; rd1 = av[i].r1; rd2 = av[i].r2;
            alu_m = av[i].am; res_w = av[i].rw; imm = av[i].im; pc = av[i].p;
            alu_ctl = av[i].ctl; alu_src = av[i].src; branch = av[i].br;
            jump = av[i].jmp; jalr = av[i].jr; funct3 = av[i].f3;
            #1;
            check($sformatf("alu%0d_res", i), alu_result, av[i].e_res);
            check($sformatf("alu%0d_zero", i), 64'(zero), 64'(av[i].e_zero));
            check($sformatf("alu%0d_pcsrc", i), 64'(pc_src), 64'(av[i].e_pcsrc));
            check($sformatf("alu%0d_tgt", i), pc_target, av[i].e_tgt);
            check($sformatf("alu%0d_wd", i), write_data, av[i].e_wd);
            check($sformatf("alu%0d_busy", i), 64'(busy), 64'd0);
            step();
        end
        imm = '0; pc = '0; alu_m = '0; res_w = '0;

        for (int i = 0; i < 17; i++)
            run_mop(mv[i].a, mv[i].b, mv[i].f3, mv[i].e_res, mv[i].lat, mv[i].name);

        // flush in cycle 10 of a MUL; a jump in the accept cycle must not redirect
        rd1 = 64'd3; rd2 = 64'd5; funct3 = 3'b000; alu_ctl = ALU_ADD; muldiv = 1'b1; jump = 1'b1;
        #1;
        check("flush_accept_busy", 64'(busy), 64'd1);
        check("muldiv_pcsrc", 64'(pc_src), 64'd0);
        jump = 1'b0;
        for (int c = 0; c < 10; c++) step();
        check("flush_pre_busy", 64'(busy), 64'(MUL_LAT > 10));
        flush = 1'b1;
        #1;
        check("flush_busy", 64'(busy), 64'd0);
        muldiv = 1'b0;
        step();
        flush = 1'b0;
        #1;
        check("flush_idle_busy", 64'(busy), 64'd0);
        check("flush_idle_result", alu_result, 64'd8);
        step();

        // reset in cycle 20 of a DIV, then a fresh MUL
        rd1 = 64'd100; rd2 = 64'd7; funct3 = 3'b100; muldiv = 1'b1;
        #1;
        check("rst_accept_busy", 64'(busy), 64'd1);
        for (int c = 0; c < 20; c++) step();
        check("rst_pre_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_busy", 64'(busy), 64'd0);
        muldiv = 1'b0;
        step();
        rst = 1'b0;
        #1;
        check("rst_idle_busy", 64'(busy), 64'd0);
        run_mop(64'd2, 64'd2, 3'b000, 64'd4, MUL_LAT, "mul_after_rst");

        // back-to-back: MulDiv_E held high across DONE, second op accepted in the next IDLE cycle
        begin
            int n;
            rd1 = 64'd10; rd2 = 64'd3; funct3 = 3'b101; muldiv = 1'b1;
            #1;
            n = 0;
            while (busy && n < 200) begin
                n++;
                step();
            end
            check("b2b_first_lat", 64'(n), 64'(DIV_LAT));
            check("b2b_first_res", alu_result, 64'd3);
            rd1 = 64'd5; rd2 = 64'd0;
            #1;
            check("b2b_done_busy", 64'(busy), 64'd0);
            step();
            check("b2b_accept_busy", 64'(busy), 64'd1);
            step();
            check("b2b_second_busy", 64'(busy), 64'd0);
            check("b2b_second_res", alu_result, ONES);
            muldiv = 1'b0;
            step();
            check("b2b_idle_busy", 64'(busy), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/execute_muldiv.md
Name: execute_muldiv

Overview:
Execute stage for the pipelined RV64I core, generalised to width XLEN and extended with a multi-cycle RV M-extension unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
- Integer ALU, branch resolution, jump-target and forwarding paths stay single-cycle combinational.
- M-ops run in an iterative FSM. While an M-op is in flight, the block raises Busy_E so the hazard unit stalls IF/ID/EX.

Parameters:
XLEN, 64, datapath width (32 or 64).
CNT_W, $clog2(XLEN)+1, iteration counter width (derived, not overridden).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
RD1_E  in  XLEN  rs1 data from ID/EX
RD2_E  in  XLEN  rs2 data from ID/EX
ImmExt_E  in  XLEN  sign-extended immediate
PC_E  in  XLEN  instruction PC
ALUResult_M  in  XLEN  forward source, MEM stage
Result_W  in  XLEN  forward source, WB stage
ALUControl_E  in  5  ALU op (existing alu encoding)
ALUSrc_E  in  1  1 = SrcB is the immediate
Branch_E  in  1  conditional branch
Jump_E  in  1  JAL/JALR
is_jalr_E  in  1  JALR target select
funct3_E  in  3  branch condition, or M-op select when MulDiv_E = 1
ForwardA_E  in  2  10 = M, 01 = W, else RD1
ForwardB_E  in  2  10 = M, 01 = W, else RD2
MulDiv_E  in  1  EX holds an M-extension op
Flush_E  in  1  kill the in-flight EX op
ALUResult_E  out  XLEN  ALU result, or M result in the DONE cycle
WriteData_E  out  XLEN  forwarded rs2
PCTarget_E  out  XLEN  branch/jump target
PCSrc_E  out  1  redirect PC
Zero_E  out  1  ALU zero flag
Busy_E  out  1  stall request to the hazard unit

Behaviour:
- Forwarding and integer path:
  - SrcA and forwarded rs2 are selected by ForwardA_E / ForwardB_E.
  - SrcB = ImmExt_E when ALUSrc_E = 1, else forwarded rs2.
  - Branch conditions follow funct3: BEQ Zero, BNE ~Zero, BLT/BLTU ALUResult[0], BGE/BGEU ~ALUResult[0]; other codes not taken.
  - PCTarget_E = PC_E + Imm, or for JALR {(SrcA + Imm)[XLEN-1:1], 0}.
  - PCSrc_E = Jump_E | (Branch_E & taken), forced to 0 when MulDiv_E = 1.
- FSM states: IDLE, MUL, DIV, DONE.
- Accept (cycle 0): state is IDLE, MulDiv_E = 1, Flush_E = 0.
  - Busy_E = 1 combinationally in this cycle.
  - The forwarded operands are latched at the clock edge, because M/W values are not stable across the stall.
- MUL path (funct3 = 0xx):
  - Shift-add on operand magnitudes, XLEN iterations, one per cycle, in state MUL.
  - Result is a 2*XLEN-bit product, sign-corrected at the end.
  - MUL returns the low half. MULH is signed×signed, MULHSU is signed×unsigned, MULHU is unsigned×unsigned; all three return the high half.
- DIV path (funct3 = 1xx):
  - Restoring division on magnitudes, XLEN iterations, in state DIV.
  - Quotient sign = sign(a) XOR sign(b). Remainder takes the dividend's sign.
  - Sign correction applies to DIV and REM only.
- Special divide cases, detected at accept: go directly to DONE, giving 1 Busy cycle and DONE in cycle 1.
  - Divide by zero: quotient = all ones, remainder = dividend.
  - Signed overflow (most-negative / -1): quotient = dividend, remainder = 0.
- Latency: Busy_E is high from cycle 0 through cycle XLEN (XLEN+1 cycles). The DONE state is cycle XLEN+1.
- DONE state:
  - Busy_E = 0 and ALUResult_E = the registered M result; EX/MEM captures it at the end of this cycle.
  - Next state is IDLE unconditionally, even if MulDiv_E is still high, so the same op never restarts.
  - A back-to-back M-op is accepted in the following IDLE cycle.
- ALUResult_E outside DONE: alu output. Zero_E always comes from the alu.
- Flush_E (any state): next state IDLE and Busy_E = 0 in the same cycle. Flush has priority over accept.
- Reset:
  - State IDLE; counter, operand registers and result register cleared to 0.
  - Busy_E = 0 during and after reset.
  - Reset mid-operation abandons the op.

Optional Feature:
MULDIV_FAST_MUL_EN
- Defined: MUL-class ops compute the product with a single-cycle combinational multiplier, registered at accept. Accept cycle has Busy_E = 1; next cycle is DONE. Total Busy is 1 cycle.
- Undefined: MUL-class ops use the iterative XLEN-cycle path.
- The DIV path is identical in both builds.

Test Plan:
- ADD with ForwardA_E = 10, ALUResult_M = 5, RD2_E = 7, ALUSrc_E = 0 -> ALUResult_E = 12, Busy_E = 0, PCSrc_E = 0.
- BLT with SrcA = -1, SrcB = 1, PC_E = 0x100, Imm = 0x20 -> PCSrc_E = 1, PCTarget_E = 0x120. JALR with SrcA = 0x205, Imm = 0 -> PCTarget_E = 0x204.
- MUL 3 × -4 (XLEN = 64) -> Busy_E high 65 cycles, then DONE with ALUResult_E = 0xFFFF_FFFF_FFFF_FFF4. MULHU all-ones × all-ones -> 0xFFFF_FFFF_FFFF_FFFE.
- DIV -7/2 -> 0xFFFF_FFFF_FFFF_FFFD (-3). REM -7/2 -> all-ones (-1). DIVU 10/3 -> 3. REMU 10/3 -> 1.
- DIVU 5/0 -> all-ones. REM 5/0 -> 5. DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000. Each has Busy for 1 cycle and DONE in cycle 1.
- Flush_E at cycle 10 of a MUL -> Busy_E = 0 that cycle, IDLE next. rst at cycle 20 of a DIV -> Busy_E = 0, a new MUL 2×2 then returns 4. Back-to-back M-ops are both accepted, with a single IDLE cycle between them.
